// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg
//   Shared constants for the instruction fetch stage: data width, instruction
//   size in bytes and the fetch FSM state encodings.
//   No ports; imported by fetch_unit_if, fetch_pc_gen and fetch_unit.
package fetch_unit_pkg;

    localparam int DATA_WIDTH  = 32;
    localparam int INSTR_BYTES = 4;

    localparam logic [1:0] FETCH_REQ  = 2'd0;
    localparam logic [1:0] FETCH_WAIT = 2'd1;
    localparam logic [1:0] FETCH_PUSH = 2'd2;
    localparam logic [1:0] FETCH_DROP = 2'd3;

endpackage

// File: rtl/fetch_unit_if.sv
// fetch_unit_if
//   Bundles the instruction-memory request/response signals and the FIFO
//   write side used by the fetch stage.
//   Signals:
//     imem_req_valid / imem_req_ready / imem_req_addr : request channel
//     imem_rsp_valid / imem_rsp_data                  : response strobe + word
//     fifo_full / fifo_wrt_en / fifo_wrt_data         : FIFO write side
//   Modports: master = fetch unit side, slave = memory/FIFO side.
//
// Handshake: a request transfers on a rising clk edge where imem_req_valid
// and imem_req_ready are both high. Once raised, valid depends only on the
// fetch unit's state and inputs, never on ready. The memory returns exactly
// one imem_rsp_valid pulse per transferred request, no earlier than the
// cycle after the transfer. A FIFO push happens on every edge where
// fifo_wrt_en is high; the fetch unit never raises it while fifo_full is high.
interface fetch_unit_if #(
    parameter int ADDR_WIDTH = 32
);
    import fetch_unit_pkg::*;

    logic                  imem_req_valid;
    logic [ADDR_WIDTH-1:0] imem_req_addr;
    logic                  imem_req_ready;
    logic                  imem_rsp_valid;
    logic [DATA_WIDTH-1:0] imem_rsp_data;
    logic                  fifo_full;
    logic                  fifo_wrt_en;
    logic [DATA_WIDTH-1:0] fifo_wrt_data;

    modport master (
        output imem_req_valid, imem_req_addr,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
        input  fifo_full,
        output fifo_wrt_en, fifo_wrt_data
    );

    modport slave (
        input  imem_req_valid, imem_req_addr,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data,
        output fifo_full,
        input  fifo_wrt_en, fifo_wrt_data
    );

endinterface

// File: rtl/fetch_unit_pc_gen.sv
// fetch_pc_gen
//   Program counter register for the fetch stage.
//   Ports:
//     clk, reset : clock, synchronous active-high reset (pc_q <= RESET_PC)
//     load       : take load_pc (redirect); has priority over inc
//     load_pc    : redirect target, bits [1:0] forced to zero
//     inc        : advance by one instruction (wraps mod 2^ADDR_WIDTH)
//     pc_q       : current PC, always word aligned
module fetch_pc_gen
    import fetch_unit_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load,
    input  logic [ADDR_WIDTH-1:0] load_pc,
    input  logic                  inc,
    output logic [ADDR_WIDTH-1:0] pc_q
);

    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = {{(ADDR_WIDTH-2){1'b1}}, 2'b00};
    localparam logic [ADDR_WIDTH-1:0] PC_STEP    = ADDR_WIDTH'(INSTR_BYTES);

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q <= RESET_PC & ALIGN_MASK;
        end else if (load) begin
            pc_q <= load_pc & ALIGN_MASK;
        end else if (inc) begin
            pc_q <= pc_q + PC_STEP;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit
//   Instruction fetch stage: holds the PC, issues one instruction-memory
//   request at a time, captures the returned word and pushes it into the
//   instruction FIFO. Redirects discard any fetch in flight.
//   Ports:
//     clk, reset       : clock, synchronous active-high reset
//     fetch_en         : 0 holds off new requests
//     redirect_valid   : single-cycle redirect strobe
//     redirect_pc      : redirect target (bits [1:0] ignored)
//     bus (master)     : imem request/response and FIFO write side
//     state_dbg        : current FSM state (FETCH_* encodings)
//     fetch_cnt        : pushes so far         (FETCH_PERF_CNT_EN only)
//     stall_cnt        : PUSH cycles with FIFO full (FETCH_PERF_CNT_EN only)
//   Build option: define FETCH_PERF_CNT_EN to add the two wrapping counters.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  fetch_en,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_pc,
    fetch_unit_if.master          bus,
`ifdef FETCH_PERF_CNT_EN
    output logic [31:0]           fetch_cnt,
    output logic [31:0]           stall_cnt,
`endif
    output logic [1:0]            state_dbg
);

    logic [1:0]            state_q;
    logic [1:0]            state_d;
    logic [DATA_WIDTH-1:0] instr_q;
    logic [ADDR_WIDTH-1:0] pc_q;
    logic                  req_fire;
    logic                  push;

    // Outputs are masked while reset is held so the first reset cycle is
    // already quiet, even if the FSM was mid-fetch.
    assign bus.imem_req_valid = !reset && (state_q == FETCH_REQ) && fetch_en && !redirect_valid;
    assign bus.imem_req_addr  = pc_q;
    assign req_fire           = bus.imem_req_valid && bus.imem_req_ready;

    // Redirect beats a push: the held word belongs to the old path.
    assign push               = !reset && (state_q == FETCH_PUSH) && !bus.fifo_full && !redirect_valid;
    assign bus.fifo_wrt_en    = push;
    assign bus.fifo_wrt_data  = reset ? '0 : instr_q;

    assign state_dbg          = state_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            FETCH_REQ: begin
                if (!redirect_valid && req_fire) state_d = FETCH_WAIT;
            end
            FETCH_WAIT: begin
                // A redirect without the response must still swallow the
                // response that is on its way (DROP); with it, we are done.
                if (redirect_valid)          state_d = bus.imem_rsp_valid ? FETCH_REQ : FETCH_DROP;
                else if (bus.imem_rsp_valid) state_d = FETCH_PUSH;
            end
            FETCH_PUSH: begin
                if (redirect_valid || !bus.fifo_full) state_d = FETCH_REQ;
            end
            FETCH_DROP: begin
                if (bus.imem_rsp_valid) state_d = FETCH_REQ;
            end
            default: state_d = FETCH_REQ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= FETCH_REQ;
            instr_q <= '0;
        end else begin
            state_q <= state_d;
            if ((state_q == FETCH_WAIT) && bus.imem_rsp_valid && !redirect_valid) begin
                instr_q <= bus.imem_rsp_data;
            end
        end
    end

    // A redirect updates the PC in every state.
    fetch_pc_gen #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .RESET_PC   (RESET_PC)
    ) u_pc_gen (
        .clk     (clk),
        .reset   (reset),
        .load    (redirect_valid),
        .load_pc (redirect_pc),
        .inc     (push),
        .pc_q    (pc_q)
    );

`ifdef FETCH_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_cnt <= '0;
            stall_cnt <= '0;
        end else begin
            if (push) fetch_cnt <= fetch_cnt + 32'd1;
            if ((state_q == FETCH_PUSH) && bus.fifo_full) stall_cnt <= stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit
//   Directed scenarios (basic fetch, FIFO stall, redirects in WAIT/PUSH,
//   PC wrap, reset during WAIT) followed by randomized traffic. A memory
//   model answers requests with a programmable latency; a scoreboard queue
//   holds the instruction words expected at the FIFO and is flushed on
//   redirect and reset.
module tb_fetch_unit;
    import fetch_unit_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        fetch_en;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [1:0]  state_dbg;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_cnt;
    logic [31:0] stall_cnt;
`endif

    fetch_unit_if #(.ADDR_WIDTH(32)) bus ();

    fetch_unit #(
        .ADDR_WIDTH (32),
        .RESET_PC   (32'h0)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .fetch_en       (fetch_en),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .bus            (bus),
`ifdef FETCH_PERF_CNT_EN
        .fetch_cnt      (fetch_cnt),
        .stall_cnt      (stall_cnt),
`endif
        .state_dbg      (state_dbg)
    );

    // ---------------- clock / global timeout ----------------
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL global_timeout: simulation did not reach the end");
        $fatal(1, "timeout");
    end

    // ---------------- bookkeeping ----------------
    int          vectors     = 0;
    int          miscompares = 0;
    int          cyc         = 0;
    logic [31:0] exp_q[$];
    logic [31:0] exp_pc      = 32'h0;
    int          outstanding = 0;
    int          push_count  = 0;
    int          due_q[$];
    logic [31:0] rsp_q[$];
    int          last_due    = 0;
    int          lat_min     = 1;
    int          lat_max     = 1;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0) return 32'h0050_0093;
        return (a * 32'h9E37_79B1) ^ 32'hA5A5_0000;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Leaves the caller at the negedge of the cycle in which a request transfers.
    task automatic wait_hs(input string name);
        int n = 0;
        @(negedge clk);
        while (!(bus.imem_req_valid && bus.imem_req_ready) && n < 40) begin
            step();
            @(negedge clk);
            n++;
        end
        chk({name, "_hs_timeout"}, 32'(n < 40), 32'd1);
    endtask

    // ---------------- memory responder ----------------
    initial begin
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = '0;
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            if (due_q.size() > 0 && due_q[0] == cyc) begin
                void'(due_q.pop_front());
                bus.imem_rsp_data  = rsp_q.pop_front();
                bus.imem_rsp_valid = 1'b1;
                if (outstanding > 0) outstanding--;
            end else begin
                bus.imem_rsp_valid = 1'b0;
                bus.imem_rsp_data  = $urandom;
            end
        end
    end

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        if (reset) begin
            exp_q.delete();
            exp_pc      = 32'h0;
            outstanding = 0;
            push_count  = 0;
        end else begin
            if (bus.imem_req_valid) begin
                chk("req_gate", 32'({fetch_en, redirect_valid}), 32'd2);
                chk("req_single_outstanding", 32'(outstanding == 0), 32'd1);
            end
            if (bus.imem_req_valid && bus.imem_req_ready) begin
                int due;
                chk("req_addr", bus.imem_req_addr, exp_pc);
                exp_q.push_back(mem_word(bus.imem_req_addr));
                exp_pc = bus.imem_req_addr + 32'd4;
                outstanding++;
                due = cyc + $urandom_range(lat_max, lat_min);
                if (due <= last_due) due = last_due + 1;
                last_due = due;
                due_q.push_back(due);
                rsp_q.push_back(mem_word(bus.imem_req_addr));
            end
            if (bus.fifo_wrt_en) begin
                push_count++;
                chk("push_gate", 32'({bus.fifo_full, redirect_valid}), 32'd0);
                chk("push_pending", 32'(exp_q.size() > 0), 32'd1);
                if (exp_q.size() > 0) chk("push_data", bus.fifo_wrt_data, exp_q.pop_front());
            end
            if (redirect_valid) begin
                exp_q.delete();
                exp_pc = redirect_pc & ~32'h3;
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        reset              = 1'b1;
        fetch_en           = 1'b1;
        redirect_valid     = 1'b0;
        redirect_pc        = 32'h0;
        bus.imem_req_ready = 1'b1;
        bus.fifo_full      = 1'b0;
        lat_min            = 1;
        lat_max            = 1;
        step();
        step();

        // Reset state
        @(negedge clk);
        chk("rst_state", 32'(state_dbg), 32'(FETCH_REQ));
        chk("rst_req_valid", 32'(bus.imem_req_valid), 32'd0);
        chk("rst_wrt_en", 32'(bus.fifo_wrt_en), 32'd0);
        chk("rst_wrt_data", bus.fifo_wrt_data, 32'd0);
`ifdef FETCH_PERF_CNT_EN
        chk("rst_fetch_cnt", fetch_cnt, 32'd0);
        chk("rst_stall_cnt", stall_cnt, 32'd0);
`endif

        // 1: basic fetch, 3 cycles per instruction
        step();
        reset = 1'b0;
        @(negedge clk);
        chk("t1_req_valid_c0", 32'(bus.imem_req_valid), 32'd1);
        chk("t1_req_addr_c0", bus.imem_req_addr, 32'h0);
        step();
        @(negedge clk);
        chk("t1_no_push_c1", 32'(bus.fifo_wrt_en), 32'd0);
        chk("t1_no_req_c1", 32'(bus.imem_req_valid), 32'd0);
        step();
        @(negedge clk);
        chk("t1_push_c2", 32'(bus.fifo_wrt_en), 32'd1);
        chk("t1_push_data_c2", bus.fifo_wrt_data, 32'h0050_0093);
        step();
        @(negedge clk);
        chk("t1_req_valid_c3", 32'(bus.imem_req_valid), 32'd1);
        chk("t1_req_addr_c3", bus.imem_req_addr, 32'h4);

        // 2: FIFO full for 5 PUSH cycles
        step();
        bus.fifo_full = 1'b1;
        begin
            int n = 0;
            @(negedge clk);
            while (state_dbg != FETCH_PUSH && n < 20) begin
                step();
                @(negedge clk);
                n++;
            end
            chk("t2_reach_push", 32'(n < 20), 32'd1);
        end
        for (int i = 0; i < 5; i++) begin
            chk("t2_stall_no_push", 32'(bus.fifo_wrt_en), 32'd0);
            chk("t2_stall_data", bus.fifo_wrt_data, mem_word(32'h4));
            step();
            if (i < 4) @(negedge clk);
        end
        bus.fifo_full = 1'b0;
        @(negedge clk);
        chk("t2_push_after_stall", 32'(bus.fifo_wrt_en), 32'd1);
        chk("t2_push_data", bus.fifo_wrt_data, mem_word(32'h4));
`ifdef FETCH_PERF_CNT_EN
        chk("t2_stall_cnt", stall_cnt, 32'd5);
        chk("t2_fetch_cnt", fetch_cnt, 32'd1);
`endif
        step();

        // 3: redirect in WAIT, response one cycle later is dropped
        lat_min = 2;
        lat_max = 2;
        wait_hs("t3");
        step();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h103;
        @(negedge clk);
        chk("t3_no_push_wait", 32'(bus.fifo_wrt_en), 32'd0);
        step();
        redirect_valid = 1'b0;
        lat_min = 1;
        lat_max = 1;
        @(negedge clk);
        chk("t3_no_push_drop", 32'(bus.fifo_wrt_en), 32'd0);
        chk("t3_no_req_drop", 32'(bus.imem_req_valid), 32'd0);
        step();
        @(negedge clk);
        chk("t3_req_valid", 32'(bus.imem_req_valid), 32'd1);
        chk("t3_req_addr", bus.imem_req_addr, 32'h100);

        // 4: redirect and response in the same WAIT cycle
        step();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h200;
        @(negedge clk);
        chk("t4_no_push", 32'(bus.fifo_wrt_en), 32'd0);
        step();
        redirect_valid = 1'b0;
        @(negedge clk);
        chk("t4_req_valid", 32'(bus.imem_req_valid), 32'd1);
        chk("t4_req_addr", bus.imem_req_addr, 32'h200);

        // 5: redirect in PUSH wins, then PC wrap
        step();
        step();
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFC;
        @(negedge clk);
        chk("t5_no_push", 32'(bus.fifo_wrt_en), 32'd0);
        step();
        redirect_valid = 1'b0;
        @(negedge clk);
        chk("t5_req_addr_top", bus.imem_req_addr, 32'hFFFF_FFFC);
        chk("t5_req_valid_top", 32'(bus.imem_req_valid), 32'd1);
        step();
        step();
        lat_min = 3;
        lat_max = 3;
        @(negedge clk);
        chk("t5_push_top", 32'(bus.fifo_wrt_en), 32'd1);
        chk("t5_push_data_top", bus.fifo_wrt_data, mem_word(32'hFFFF_FFFC));
        step();
        @(negedge clk);
        chk("t5_wrap_valid", 32'(bus.imem_req_valid), 32'd1);
        chk("t5_wrap_addr", bus.imem_req_addr, 32'h0);

        // 6: reset while in WAIT, late response is ignored
        step();
        reset = 1'b1;
        @(negedge clk);
        chk("t6_rst_req_valid", 32'(bus.imem_req_valid), 32'd0);
        chk("t6_rst_wrt_en", 32'(bus.fifo_wrt_en), 32'd0);
        step();
        reset              = 1'b0;
        bus.imem_req_ready = 1'b0;
        @(negedge clk);
        chk("t6_state", 32'(state_dbg), 32'(FETCH_REQ));
        chk("t6_req_valid", 32'(bus.imem_req_valid), 32'd1);
        chk("t6_req_addr", bus.imem_req_addr, 32'h0);
        chk("t6_wrt_data", bus.fifo_wrt_data, 32'd0);
`ifdef FETCH_PERF_CNT_EN
        chk("t6_fetch_cnt", fetch_cnt, 32'd0);
        chk("t6_stall_cnt", stall_cnt, 32'd0);
`endif
        step();
        @(negedge clk);
        chk("t6_late_rsp_no_push", 32'(bus.fifo_wrt_en), 32'd0);
        chk("t6_late_rsp_state", 32'(state_dbg), 32'(FETCH_REQ));

        // Randomized traffic
        step();
        bus.imem_req_ready = 1'b1;
        lat_min = 1;
        lat_max = 3;
        begin
            int base = push_count;
            for (int i = 0; i < 3000; i++) begin
                fetch_en           = ($urandom_range(0, 9) != 0);
                bus.imem_req_ready = ($urandom_range(0, 3) != 0);
                bus.fifo_full      = ($urandom_range(0, 3) == 0);
                redirect_valid     = ($urandom_range(0, 14) == 0);
                redirect_pc        = ($urandom_range(0, 7) == 0) ?
                                     32'hFFFF_FFF0 + 32'($urandom_range(0, 15)) :
                                     32'($urandom_range(0, 1023));
                step();
            end
            fetch_en       = 1'b0;
            redirect_valid = 1'b0;
            bus.fifo_full  = 1'b0;
            for (int i = 0; i < 20; i++) step();
            @(negedge clk);
            chk("rand_progress", 32'((push_count - base) >= 50), 32'd1);
            chk("rand_drained", 32'(exp_q.size()), 32'd0);
            chk("rand_idle_state", 32'(state_dbg), 32'(FETCH_REQ));
`ifdef FETCH_PERF_CNT_EN
            chk("rand_fetch_cnt", fetch_cnt, 32'(push_count));
`endif
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
